// File: rtl/stage_mem.sv
`timescale 1ns/1ps
// stage_mem: MEM pipeline register plus the req/ack data-memory handshake.
// Loads and stores hold the pipeline in REQ until dm_ack arrives or the wait
// counter expires. An expired transaction sets a sticky error flag.
//
//   state | meaning
//   IDLE  | M holds a non-memory op (or reset value), result visible, capturing
//   REQ   | memory transaction in flight, M frozen, upstream stalled
//   DONE  | memory op finished this cycle, result visible, capturing
module stage_mem #(
    parameter int TIMEOUT  = 15,
    parameter int RF_SRC_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         ex_pc,
    input  logic [31:0]         ex_inst,
    input  logic [31:0]         ex_opResult,
    input  logic                ex_memWE,
    input  logic [31:0]         ex_memData,
    input  logic                ex_rfWE,
    input  logic [4:0]          ex_rfDst,
    input  logic [RF_SRC_W-1:0] ex_rfSrc,
    output logic [31:0]         mem_pc,
    output logic [31:0]         mem_inst,
    output logic                mem_rfWE,
    output logic [4:0]          mem_rfDst,
    output logic [31:0]         mem_rfData,
    output logic                mem_stall,
    output logic                mem_timeout,
    output logic                dm_req,
    output logic                dm_we,
    output logic [31:0]         dm_addr,
    output logic [31:0]         dm_wdata,
    input  logic                dm_ack,
    input  logic [31:0]         dm_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         inst_q, inst_d;
    logic [31:0]         opres_q, opres_d;
    logic                memwe_q, memwe_d;
    logic [31:0]         memdata_q, memdata_d;
    logic                rfwe_q, rfwe_d;
    logic [4:0]          rfdst_q, rfdst_d;
    logic [RF_SRC_W-1:0] rfsrc_q, rfsrc_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                timeout_q, timeout_d;

    logic ex_is_mem;
    logic m_is_load;

    // A store wins over rfSrc=01; only a non-store with rfSrc=01 is a load.
    assign ex_is_mem = ex_memWE || (ex_rfSrc == RF_SRC_W'(1));
    assign m_is_load = !memwe_q && (rfsrc_q == RF_SRC_W'(1));

    // State and pipeline register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            opres_q   <= '0;
            memwe_q   <= 1'b0;
            memdata_q <= '0;
            rfwe_q    <= 1'b0;
            rfdst_q   <= '0;
            rfsrc_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            opres_q   <= opres_d;
            memwe_q   <= memwe_d;
            memdata_q <= memdata_d;
            rfwe_q    <= rfwe_d;
            rfdst_q   <= rfdst_d;
            rfsrc_q   <= rfsrc_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state: capture whenever not in REQ, otherwise wait for ack or abort.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        opres_d   = opres_q;
        memwe_d   = memwe_q;
        memdata_d = memdata_q;
        rfwe_d    = rfwe_q;
        rfdst_d   = rfdst_q;
        rfsrc_d   = rfsrc_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q != REQ) begin
            pc_d      = ex_pc;
            inst_d    = ex_inst;
            opres_d   = ex_opResult;
            memwe_d   = ex_memWE;
            memdata_d = ex_memData;
            rfwe_d    = ex_rfWE;
            rfdst_d   = ex_rfDst;
            rfsrc_d   = ex_rfSrc;
            cnt_d     = '0;
            state_d   = ex_is_mem ? REQ : IDLE;
        end else if (dm_ack) begin
            if (m_is_load) begin
                rdata_d = dm_rdata;
            end
            state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            rdata_d   = '0;
            state_d   = DONE;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Write-back data selection straight from the MEM register.
    always_comb begin
        mem_rfData = '0;
        if (rfsrc_q == RF_SRC_W'(0)) begin
            mem_rfData = opres_q;
        end else if (rfsrc_q == RF_SRC_W'(1)) begin
            mem_rfData = rdata_q;
        end else if (rfsrc_q == RF_SRC_W'(2)) begin
            mem_rfData = pc_q + 32'd8;
        end
    end

    assign mem_pc      = pc_q;
    assign mem_inst    = inst_q;
    assign mem_rfDst   = rfdst_q;
    assign mem_stall   = (state_q == REQ);
    assign mem_rfWE    = rfwe_q && (state_q != REQ);
    assign mem_timeout = timeout_q;
    assign dm_req      = (state_q == REQ);
    assign dm_we       = memwe_q;
    assign dm_addr     = {opres_q[31:2], 2'b00};
    assign dm_wdata    = memdata_q;

endmodule

// File: tb/tb_stage_mem.sv
`timescale 1ns/1ps
// tb_stage_mem: random op stream with a queue-based scoreboard and a
// memory responder that acks after a chosen number of REQ cycles.
module tb_stage_mem;

    localparam int TIMEOUT = 15;
    localparam int N_RAND  = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ex_pc = '0, ex_inst = '0, ex_opResult = '0, ex_memData = '0;
    logic        ex_memWE = 1'b0, ex_rfWE = 1'b0;
    logic [4:0]  ex_rfDst = '0;
    logic [1:0]  ex_rfSrc = '0;
    logic [31:0] mem_pc, mem_inst, mem_rfData, dm_addr, dm_wdata;
    logic        mem_rfWE, mem_stall, mem_timeout, dm_req, dm_we;
    logic [4:0]  mem_rfDst;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;

    always #5 clk = ~clk;

    stage_mem #(.TIMEOUT(TIMEOUT), .RF_SRC_W(2)) dut (
        .clk(clk), .rst(rst),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_opResult(ex_opResult),
        .ex_memWE(ex_memWE), .ex_memData(ex_memData), .ex_rfWE(ex_rfWE),
        .ex_rfDst(ex_rfDst), .ex_rfSrc(ex_rfSrc),
        .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rfWE(mem_rfWE),
        .mem_rfDst(mem_rfDst), .mem_rfData(mem_rfData), .mem_stall(mem_stall),
        .mem_timeout(mem_timeout), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    typedef struct {
        logic [31:0] pc, inst, rfdata, addr, wdata;
        logic        rfwe, we, timeout;
        logic [4:0]  rfdst;
        int          stall;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    int          stall_cnt = 0;
    // reference model state: last loaded word and sticky abort flag
    logic [31:0] m_rdata = '0;
    bit          m_to = 1'b0;
    // responder state for the op in flight
    int          cur_k = 0;
    int          req_cnt = 0;
    logic [31:0] cur_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one op on ex_* and push the response the spec rules predict.
    // k = REQ cycle in which the memory acks; k > TIMEOUT means never.
    task automatic drive_op(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] opres, input logic memwe,
                            input logic [31:0] memdata, input logic rfwe,
                            input logic [4:0] rfdst, input logic [1:0] rfsrc,
                            input int k, input logic [31:0] rdata);
        exp_t e;
        ex_pc = pc; ex_inst = inst; ex_opResult = opres; ex_memWE = memwe;
        ex_memData = memdata; ex_rfWE = rfwe; ex_rfDst = rfdst; ex_rfSrc = rfsrc;
        e.stall = 0;
        if (memwe || rfsrc == 2'd1) begin
            cur_k = k; req_cnt = 0; cur_rdata = rdata;
            if (k <= TIMEOUT) begin
                e.stall = k;
                if (!memwe) m_rdata = rdata;
            end else begin
                e.stall = TIMEOUT;
                m_to = 1'b1;
                m_rdata = '0;
            end
        end
        e.pc = pc; e.inst = inst; e.rfwe = rfwe; e.rfdst = rfdst;
        e.addr = opres & 32'hFFFF_FFFC; e.we = memwe; e.wdata = memdata;
        e.timeout = m_to;
        case (rfsrc)
            2'd0:    e.rfdata = opres;
            2'd1:    e.rfdata = m_rdata;
            2'd2:    e.rfdata = pc + 32'd8;
            default: e.rfdata = 32'd0;
        endcase
        expq.push_back(e);
    endtask

    // Memory model: ack in the chosen REQ cycle; random junk acks outside REQ.
    task automatic respond();
        if (dm_req) begin
            req_cnt++;
            dm_ack = (req_cnt == cur_k);
            dm_rdata = dm_ack ? cur_rdata : $urandom;
        end else begin
            dm_ack = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
        end
    endtask

    task automatic drive_next(input int idx);
        int k;
        logic [1:0] src;
        k = $urandom_range(1, TIMEOUT + 2);
        case (idx)
            0: drive_op(32'h100, 32'h11, 32'h0000_1234, 0, 32'h0, 1, 5'd5, 2'd0, 1, 0);
            1: drive_op(32'h104, 32'h22, 32'h0000_0103, 0, 32'h0, 1, 5'd8, 2'd1, 3, 32'hDEAD_BEEF);
            2: drive_op(32'h108, 32'h33, 32'h0000_0200, 1, 32'hCAFE_F00D, 0, 5'd0, 2'd0, 1, 0);
            3: drive_op(32'h10C, 32'h44, 32'h0000_0044, 0, 32'h0, 1, 5'd3, 2'd1, TIMEOUT + 5, 0);
            4: drive_op(32'h110, 32'h55, 32'h0000_0058, 0, 32'h0, 1, 5'd4, 2'd1, 2, 32'h0000_0055);
            5: drive_op(32'h400, 32'h66, 32'h0000_0999, 0, 32'h0, 1, 5'd31, 2'd2, 1, 0);
            6: drive_op(32'h118, 32'h77, 32'h0000_0ABC, 0, 32'h0, 1, 5'd9, 2'd1, TIMEOUT, 32'hA5A5_A5A5);
            7: drive_op(0, 0, 0, 0, 0, 0, 5'd0, 2'd0, 1, 0);
            default: begin
                if ($urandom_range(0, 7) == 0) begin
                    drive_op(0, 0, 0, 0, 0, 0, 5'd0, 2'd0, 1, 0);
                end else begin
                    src = 2'($urandom_range(0, 3));
                    drive_op($urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0),
                             $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                             src, k, $urandom);
                end
            end
        endcase
    endtask

    // Scoreboard monitor: stall cycles check the port, other cycles pop a result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL queue_empty: got output with no expected entry at %0t", $time);
            end else if (mem_stall) begin
                stall_cnt++;
                chk("req_dm_req", 32'(dm_req), 32'd1);
                chk("req_dm_addr", dm_addr, expq[0].addr);
                chk("req_dm_we", 32'(dm_we), 32'(expq[0].we));
                chk("req_dm_wdata", dm_wdata, expq[0].wdata);
                chk("req_rfwe_low", 32'(mem_rfWE), 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                chk("dm_req_idle", 32'(dm_req), 32'd0);
                chk("mem_pc", mem_pc, e.pc);
                chk("mem_inst", mem_inst, e.inst);
                chk("mem_rfWE", 32'(mem_rfWE), 32'(e.rfwe));
                chk("mem_rfDst", 32'(mem_rfDst), 32'(e.rfdst));
                chk("mem_rfData", mem_rfData, e.rfdata);
                chk("mem_timeout", 32'(mem_timeout), 32'(e.timeout));
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        // reset with non-zero ex_* held
        ex_pc = 32'hFFFF_FFF0; ex_inst = 32'h1234_5678; ex_opResult = 32'h0000_0103;
        ex_memWE = 1'b1; ex_memData = 32'h5555_AAAA; ex_rfWE = 1'b1; ex_rfDst = 5'd7;
        ex_rfSrc = 2'd1; dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_pc", mem_pc, 0);
        chk("rst_mem_inst", mem_inst, 0);
        chk("rst_mem_rfWE", 32'(mem_rfWE), 0);
        chk("rst_mem_rfDst", 32'(mem_rfDst), 0);
        chk("rst_mem_rfData", mem_rfData, 0);
        chk("rst_mem_stall", 32'(mem_stall), 0);
        chk("rst_mem_timeout", 32'(mem_timeout), 0);
        chk("rst_dm_req", 32'(dm_req), 0);

        @(posedge clk); #1;
        rst = 1'b0;
        dm_ack = 1'b0;
        drive_next(0);
        for (int i = 1; i < 8 + N_RAND; ) begin
            @(posedge clk); #1;
            mon_en = 1'b1;
            respond();
            if (!mem_stall) begin
                drive_next(i);
                i++;
            end
        end
        // let the last op complete, then stop the monitor
        guard = 0;
        do begin
            @(posedge clk); #1;
            respond();
            guard++;
        end while (mem_stall && guard < 4 * TIMEOUT);
        chk("drain_bound", 32'(mem_stall), 0);
        @(negedge clk); #1;
        mon_en = 1'b0;
        chk("queue_drained", 32'(expq.size()), 0);

        // reset in the 2nd REQ cycle of a load, then a stale ack
        dm_ack = 1'b0;
        ex_pc = 32'h500; ex_inst = 32'h88; ex_opResult = 32'h0000_0301; ex_memWE = 1'b0;
        ex_memData = 32'h0; ex_rfWE = 1'b1; ex_rfDst = 5'd10; ex_rfSrc = 2'd1;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("midrst_req_cycle1", 32'(dm_req), 1);
        @(posedge clk); #1;
        chk("midrst_req_cycle2", 32'(dm_req), 1);
        rst = 1'b1;
        ex_pc = '0; ex_inst = '0; ex_opResult = '0; ex_rfWE = 1'b0; ex_rfDst = '0; ex_rfSrc = '0;
        @(posedge clk); #1;
        chk("midrst_dm_req", 32'(dm_req), 0);
        chk("midrst_stall", 32'(mem_stall), 0);
        chk("midrst_timeout", 32'(mem_timeout), 0);
        chk("midrst_rfData", mem_rfData, 0);
        rst = 1'b0;
        dm_ack = 1'b1;
        dm_rdata = 32'h1234_5678;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stale_ack_dm_req", 32'(dm_req), 0);
            chk("stale_ack_stall", 32'(mem_stall), 0);
            chk("stale_ack_rfData", mem_rfData, 0);
            chk("stale_ack_timeout", 32'(mem_timeout), 0);
        end
        dm_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
